seg7_scan_driver: RTL and testbench

- Downstream display stage of the joystick-position measurement chain.
- Consumes the validated 7-bit count strobed out of the capture register after each triangle period.
- Converts the count to BCD with a sequential shift-add-3 (double-dabble) engine and drives a time-multiplexed common-anode/cathode-agnostic 7-segment display.
- Commits new values only at a frame boundary, so a refresh never shows a torn number.

---
 rtl/seg7_scan_driver.sv | 192 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-dabble BCD converter feeding a multiplexed 7-segment scan
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zero digits above digit 0).
module seg7_scan_driver #(
  parameter int WIDTH       = 7,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK       = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              frame
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONVERT, PENDING} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx;
  logic [WIDTH-1:0]  r_hold;
  logic [WIDTH-1:0]  r_bin;
  logic [BW-1:0]     r_bcd;
  logic [BW-1:0]     r_disp;
  logic [BW-1:0]     w_adj;
  logic [CW-1:0]     r_cnt;
  logic              r_redo;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;
  logic              w_wrap;
  logic              w_frame_bnd;
  logic              w_conv_done;
  logic              w_commit;
  logic              w_restart;
  logic [3:0]        w_digit;
  logic              w_digit_on;

  assign w_wrap      = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_frame_bnd = w_wrap && (r_idx == IW'(DIGITS - 1));
  assign w_conv_done = (r_cnt == CW'(WIDTH - 1));
  assign w_commit    = (r_state == PENDING) && w_frame_bnd;
  // A load landing on the commit cycle is treated like a busy load: the newer value is converted next.
  assign w_restart   = w_commit && (r_redo || load);

  assign seg   = r_seg;
  assign an    = r_an;
  assign busy  = (r_state != IDLE);
  assign frame = w_frame_bnd;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // Free-running slot prescaler and digit index; independent of the converter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Select the BCD nibble of the digit currently being scanned.
  always_comb begin
    w_digit = 4'd0;
    for (int d = 0; d < DIGITS; d++)
      if (r_idx == IW'(d)) w_digit = r_disp[4*d +: 4];
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Suppress a digit above digit 0 when it and every higher digit are zero.
  always_comb begin
    w_digit_on = 1'b1;
    for (int d = 1; d < DIGITS; d++)
      if (r_idx == IW'(d) && (r_disp >> (4*d)) == '0) w_digit_on = 1'b0;
  end
`else
  assign w_digit_on = 1'b1;
`endif

  // Registered drive: anti-ghost blank window at slot start, then the selected digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= '0;
      r_an  <= '0;
    end else if (r_presc < PW'(BLANK) || !w_digit_on) begin
      r_seg <= '0;
      r_an  <= '0;
    end else begin
      r_seg <= decode(w_digit);
      r_an  <= DIGITS'(1) << r_idx;
    end
  end

  // Double-dabble correction: add 3 to every nibble that is 5 or more before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++)
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state: accept, convert for WIDTH cycles, then wait for a frame boundary to commit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (load) w_next = CONVERT;
      CONVERT: if (w_conv_done) w_next = PENDING;
      PENDING: if (w_commit) w_next = w_restart ? CONVERT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Converter datapath, hold/redo bookkeeping and frame-aligned commit to the display register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
      r_redo <= 1'b0;
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_disp <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_hold <= value;
            r_bin  <= value;
            r_bcd  <= '0;
            r_cnt  <= '0;
          end
        end
        CONVERT: begin
          r_bcd <= {w_adj[BW-2:0], r_bin[WIDTH-1]};
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
          if (load) begin
            r_hold <= value;
            r_redo <= 1'b1;
          end
        end
        PENDING: begin
          if (w_commit) begin
            r_disp <= r_bcd;
            r_redo <= 1'b0;
            if (load) r_hold <= value;
            if (w_restart) begin
              r_bin <= load ? value : r_hold;
              r_bcd <= '0;
              r_cnt <= '0;
            end
          end else if (load) begin
            r_hold <= value;
            r_redo <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int WIDTH       = 7;
  localparam int DIGITS      = 3;
  localparam int REFRESH_DIV = 8;
  localparam int BLANK       = 2;
  localparam int FRAME       = REFRESH_DIV * DIGITS;

  typedef struct packed {
    logic [20:0] segs;
    logic [2:0]  seen;
    logic        torn;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [6:0] value = '0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;
  logic       frame;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_rec = 0;
  int   exp_q[$];
  rec_t cur_rec;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK(BLANK)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .seg(seg), .an(an), .busy(busy), .frame(frame)
  );

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'h3F; 1: pat = 7'h06; 2: pat = 7'h5B; 3: pat = 7'h4F; 4: pat = 7'h66;
      5: pat = 7'h6D; 6: pat = 7'h7D; 7: pat = 7'h07; 8: pat = 7'h7F; 9: pat = 7'h6F;
      default: pat = 7'h00;
    endcase
  endfunction

  // Expected picture of one full frame for a displayed decimal value.
  function automatic rec_t build_rec(input int v);
    rec_t r;
    int   p;
    r = '0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      bit show;
      show = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      show = (d == 0) || (v >= p);
`endif
      if (show) begin
        r.segs[7*d +: 7] = pat((v / p) % 10);
        r.seen[d] = 1'b1;
      end
      p = p * 10;
    end
    return r;
  endfunction

  // Frame monitor: assembles what was shown per digit over each frame, then scores changes.
  initial begin : monitor
    rec_t acc;
    rec_t e;
    logic frame_d;
    int   d;
    acc = '0;
    frame_d = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        acc = '0;
        frame_d = 1'b0;
      end else begin
        if (an !== 3'b000) begin
          case (an)
            3'b001:  d = 0;
            3'b010:  d = 1;
            3'b100:  d = 2;
            default: d = -1;
          endcase
          if (d < 0) acc.torn = 1'b1;
          else if (acc.seen[d] && acc.segs[7*d +: 7] !== seg) acc.torn = 1'b1;
          else begin
            acc.seen[d] = 1'b1;
            acc.segs[7*d +: 7] = seg;
          end
        end
        if (frame_d) begin
          n_rec++;
          if (acc !== cur_rec) begin
            n_cmp++;
            if (exp_q.size() > 0) begin
              e = build_rec(exp_q.pop_front());
              if (acc !== e) begin
                n_fail++;
                $display("FAIL frame_commit: got segs=%h seen=%b torn=%b, required segs=%h seen=%b torn=0",
                         acc.segs, acc.seen, acc.torn, e.segs, e.seen);
              end
              cur_rec = e;
            end else begin
              n_fail++;
              $display("FAIL frame_unexpected: got segs=%h seen=%b torn=%b, required segs=%h seen=%b torn=0",
                       acc.segs, acc.seen, acc.torn, cur_rec.segs, cur_rec.seen);
            end
          end
          acc = '0;
        end
        frame_d = frame;
      end
    end
  end

  task automatic pulse_load(input int v);
    value = 7'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (frame === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int t;
    reset = 1'b1;
    load = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== 3'b000 || seg !== 7'h00 || busy !== 1'b0 || frame !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: an=%b seg=%h busy=%b frame=%b, required all zero", an, seg, busy, frame);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (i < 3) begin
        if (an !== 3'b000) begin
          n_fail++;
          $display("FAIL first_slot_blank: cycle %0d an=%b, required 000", i, an);
        end
      end else if (an !== 3'b001 || seg !== 7'h3F) begin
        n_fail++;
        $display("FAIL first_slot_digit0: an=%b seg=%h, required an=001 seg=3f", an, seg);
      end
    end
    t = 3;
    while (frame !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t != FRAME - 1) begin
      n_fail++;
      $display("FAIL first_frame_cycle: got %0d, required %0d", t, FRAME - 1);
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (frame !== 1'b1 && t < 100);
    n_cmp++;
    if (t != FRAME) begin
      n_fail++;
      $display("FAIL frame_period: got %0d, required %0d", t, FRAME);
    end
  endtask

  task automatic test_load_basic();
    bit ok;
    int t;
    sync_frame(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL basic_sync: no frame pulse, required one"); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b, required 0", busy); end
    pulse_load(60);
    exp_q.push_back(60);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b, required 1", busy); end
    t = 1;
    while (busy === 1'b1 && t < 200) begin @(negedge clk); t++; end
    n_cmp++;
    if (t != FRAME + 1) begin n_fail++; $display("FAIL basic_busy_fall: cycle %0d, required %0d", t, FRAME + 1); end
    for (int i = 0; i < 6 * FRAME && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_drain: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back(input bit third);
    bit ok;
    int t;
    sync_frame(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL b2b_sync: no frame pulse, required one"); end
    pulse_load(127);
    exp_q.push_back(127);
    @(negedge clk);
    pulse_load(99);
    exp_q.push_back(99);
    t = 3;
    if (third) begin
      @(negedge clk);
      pulse_load(45);
      exp_q[exp_q.size() - 1] = 45;
      t = 5;
    end
    while (busy === 1'b1 && t < 200) begin @(negedge clk); t++; end
    n_cmp++;
    if (t != 2 * FRAME + 1) begin
      n_fail++;
      $display("FAIL b2b_busy_span: busy low at cycle %0d, required %0d (third=%0d)", t, 2 * FRAME + 1, third);
    end
    for (int i = 0; i < 6 * FRAME && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_frame_edge();
    bit ok;
    int t;
    sync_frame(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL edge_sync: no frame pulse, required one"); end
    repeat (FRAME - 1) @(negedge clk);
    pulse_load(30);
    exp_q.push_back(30);
    n_cmp++;
    if (frame !== 1'b1) begin n_fail++; $display("FAIL edge_frame: frame=%b, required 1", frame); end
    t = FRAME;
    while (busy === 1'b1 && t < 200) begin @(negedge clk); t++; end
    n_cmp++;
    if (t != 2 * FRAME + 1) begin n_fail++; $display("FAIL edge_busy_fall: cycle %0d, required %0d", t, 2 * FRAME + 1); end
    for (int i = 0; i < 6 * FRAME && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL edge_drain: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_pending();
    bit ok;
    bit bad;
    int rec0;
    sync_frame(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL rstp_sync: no frame pulse, required one"); end
    pulse_load(88);
    repeat (12) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rstp_busy_before: got %b, required 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    cur_rec = build_rec(0);
    n_cmp++;
    if (an !== 3'b000 || seg !== 7'h00 || busy !== 1'b0 || frame !== 1'b0) begin
      n_fail++;
      $display("FAIL rstp_outputs: an=%b seg=%h busy=%b frame=%b, required all zero", an, seg, busy, frame);
    end
    rec0 = n_rec;
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || (an !== 3'b000 && seg !== 7'h3F)) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL rstp_after: got busy or nonzero digit after reset, required busy=0 and seg=3f"); end
    n_cmp++;
    if (n_rec - rec0 < 2) begin n_fail++; $display("FAIL rstp_frames: got %0d frames, required at least 2", n_rec - rec0); end
  endtask

  task automatic test_leading_zero();
    bit         ok;
    logic [2:0] an_or;
    logic [2:0] an_req;
    sync_frame(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL lz_sync: no frame pulse, required one"); end
    pulse_load(7);
    exp_q.push_back(7);
    for (int i = 0; i < 6 * FRAME && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL lz_drain: %0d pending, required 0", exp_q.size()); end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    an_req = 3'b001;
`else
    an_req = 3'b111;
`endif
    an_or = 3'b000;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      an_or = an_or | an;
    end
    n_cmp++;
    if (an_or !== an_req) begin n_fail++; $display("FAIL lz_enables: got %b, required %b", an_or, an_req); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    cur_rec = build_rec(0);
    test_reset();
    test_load_basic();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_frame_edge();
    test_reset_pending();
    test_leading_zero();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
